// File: rtl/icache_refill_unit.sv
// Refill engine for L1 instruction-cache misses: one block-aligned burst read per miss,
// beats assembled in ascending order, and the full block returned with a single write pulse.
module icache_refill_unit #(
   parameter int PC_WIDTH    = 32,
   parameter int CACHE_WIDTH = 256,
   parameter int MEM_WIDTH   = 64,
   parameter int BLK_OFFSET  = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   miss_i,
   input  logic [PC_WIDTH-1:0]    missAddr_i,
   input  logic                   flush_i,
   output logic                   memReqValid_o,
   output logic [PC_WIDTH-1:0]    memReqAddr_o,
   input  logic                   memReqReady_i,
   input  logic                   memRspValid_i,
   input  logic [MEM_WIDTH-1:0]   memRspData_i,
   output logic                   wrEnable_o,
   output logic [PC_WIDTH-1:0]    wrAddr_o,
   output logic [CACHE_WIDTH-1:0] instBlock_o,
   output logic                   busy_o
);

   localparam int BEATS = CACHE_WIDTH / MEM_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [PC_WIDTH-1:0] BLK_MASK  = ~((PC_WIDTH'(1) << BLK_OFFSET) - PC_WIDTH'(1));

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_RESP  = 3'd2,
      S_WRITE = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [PC_WIDTH-1:0]     req_addr_r;
   logic [PC_WIDTH-1:0]     wr_addr_r;
   logic [CNT_W-1:0]        cnt_r;
   logic                    drop_r;
   logic [CACHE_WIDTH-1:0]  asm_r;
   logic [CACHE_WIDTH-1:0]  asm_s;
   logic [CACHE_WIDTH-1:0]  inst_block_r;

   logic capture_s;
   logic accept_s;
   logic beat_s;
   logic last_beat_s;
   logic load_fill_s;

   // A flush seen in REQ withdraws the request in the same cycle, so it can never be accepted.
   assign capture_s   = (state_r == S_IDLE) & miss_i & ~flush_i;
   assign accept_s    = (state_r == S_REQ) & ~flush_i & memReqReady_i;
   assign beat_s      = (state_r == S_RESP) & memRspValid_i;
   assign last_beat_s = beat_s & (cnt_r == LAST_BEAT);
   assign load_fill_s = last_beat_s & ~drop_r & ~flush_i;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (capture_s) begin
               state_s = S_REQ;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_REQ: begin
            if (flush_i) begin
               state_s = S_IDLE;
            end else if (memReqReady_i) begin
               state_s = S_RESP;
            end else begin
               state_s = S_REQ;
            end
         end
         S_RESP: begin
            // The burst is always drained; a pending drop only decides where it ends.
            if (last_beat_s) begin
               state_s = (drop_r | flush_i) ? S_IDLE : S_WRITE;
            end else begin
               state_s = S_RESP;
            end
         end
         S_WRITE: state_s = S_HOLD;
         S_HOLD:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      memReqValid_o = (state_r == S_REQ) & ~flush_i;
      wrEnable_o    = (state_r == S_WRITE) & ~flush_i;
      busy_o        = (state_r != S_IDLE);
      memReqAddr_o  = req_addr_r;
      wrAddr_o      = wr_addr_r;
      instBlock_o   = inst_block_r;
   end

   // Block under assembly with the current beat merged into its slot.
   always_comb begin
      asm_s = asm_r;
      for (int b = 0; b < BEATS; b++) begin
         if (cnt_r == CNT_W'(b)) begin
            asm_s[b*MEM_WIDTH +: MEM_WIDTH] = memRspData_i;
         end else begin
            asm_s[b*MEM_WIDTH +: MEM_WIDTH] = asm_r[b*MEM_WIDTH +: MEM_WIDTH];
         end
      end
   end

   // Datapath: request address, beat counter, drop flag, assembly buffer and fill outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_addr_r   <= '0;
         wr_addr_r    <= '0;
         cnt_r        <= '0;
         drop_r       <= 1'b0;
         asm_r        <= '0;
         inst_block_r <= '0;
      end else begin
         if (capture_s) begin
            req_addr_r <= missAddr_i & BLK_MASK;
         end
         if (accept_s) begin
            cnt_r  <= '0;
            drop_r <= 1'b0;
         end else if (beat_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if ((state_r == S_RESP) && flush_i) begin
            drop_r <= 1'b1;
         end
         if (beat_s) begin
            asm_r <= asm_s;
         end
         // Fill outputs change only when a block is about to be written, so they hold otherwise.
         if (load_fill_s) begin
            wr_addr_r    <= req_addr_r;
            inst_block_r <= asm_s;
         end
      end
   end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Self-checking bench for icache_refill_unit: directed spec scenarios plus randomized refills
// compared against a block-level reference model (aligned address, beats concatenated in order).
module tb_icache_refill_unit;

   localparam int BEATS = 4;

   logic         clk;
   logic         reset;
   logic         miss_i;
   logic [31:0]  missAddr_i;
   logic         flush_i;
   logic         memReqValid_o;
   logic [31:0]  memReqAddr_o;
   logic         memReqReady_i;
   logic         memRspValid_i;
   logic [63:0]  memRspData_i;
   logic         wrEnable_o;
   logic [31:0]  wrAddr_o;
   logic [255:0] instBlock_o;
   logic         busy_o;

   int vectors = 0;
   int miscompares = 0;

   // Observation state gathered every cycle by cycle_obs.
   int           accept_cnt;
   int           pulse_cnt;
   int           unstable;
   int           timeout;
   bit           valid_seen;
   logic [31:0]  first_req_addr;
   logic [31:0]  accepted_addr;
   logic [31:0]  last_wr_addr;
   logic [255:0] last_wr_block;
   logic         busy_after_last;

   logic [63:0]  beats [BEATS];

   icache_refill_unit dut (
      .clk           (clk),
      .reset         (reset),
      .miss_i        (miss_i),
      .missAddr_i    (missAddr_i),
      .flush_i       (flush_i),
      .memReqValid_o (memReqValid_o),
      .memReqAddr_o  (memReqAddr_o),
      .memReqReady_i (memReqReady_i),
      .memRspValid_i (memRspValid_i),
      .memRspData_i  (memRspData_i),
      .wrEnable_o    (wrEnable_o),
      .wrAddr_o      (wrAddr_o),
      .instBlock_o   (instBlock_o),
      .busy_o        (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_addr(input logic [31:0] a);
      return (a / 32'd32) * 32'd32;
   endfunction

   function automatic logic [255:0] model_block();
      logic [255:0] blk;
      blk = 256'd0;
      for (int i = 0; i < BEATS; i++) blk = blk | ({192'd0, beats[i]} << (64 * i));
      return blk;
   endfunction

   task automatic randomize_beats();
      for (int i = 0; i < BEATS; i++) beats[i] = {$urandom, $urandom};
   endtask

   task automatic cycle_obs();
      #1;
      if (memReqValid_o && memReqReady_i) begin
         accept_cnt++;
         accepted_addr = memReqAddr_o;
      end
      if (memReqValid_o) begin
         if (!valid_seen) begin
            valid_seen     = 1'b1;
            first_req_addr = memReqAddr_o;
         end else if (memReqAddr_o !== first_req_addr) begin
            unstable++;
         end
      end
      if (wrEnable_o) begin
         pulse_cnt++;
         last_wr_addr  = wrAddr_o;
         last_wr_block = instBlock_o;
      end
   endtask

   // flush_kind: 0 none, 1 in the gap after beat flush_beat, 2 with beat flush_beat, 3 in WRITE.
   task automatic run_refill(input logic [31:0] addr, input int ready_wait, input int gap_max,
                             input int flush_kind, input int flush_beat, input bit hold_miss,
                             input logic [31:0] alt_addr);
      int n;
      int gaps;
      accept_cnt = 0; pulse_cnt = 0; unstable = 0; timeout = 0; valid_seen = 1'b0;
      @(negedge clk);
      miss_i = 1'b1; missAddr_i = addr; flush_i = 1'b0; memReqReady_i = 1'b0; memRspValid_i = 1'b0;
      cycle_obs();
      n = 0;
      while (!memReqValid_o && n < 10) begin
         @(negedge clk); cycle_obs(); n++;
      end
      if (!memReqValid_o) timeout++;
      for (int i = 0; i < ready_wait; i++) begin
         @(negedge clk); memReqReady_i = 1'b0; cycle_obs();
      end
      @(negedge clk); memReqReady_i = 1'b1; cycle_obs();
      for (int i = 0; i < BEATS; i++) begin
         gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            memReqReady_i = 1'b0; memRspValid_i = 1'b0; memRspData_i = {$urandom, $urandom};
            flush_i = 1'b0;
            cycle_obs();
         end
         @(negedge clk);
         memReqReady_i = 1'b0; memRspValid_i = 1'b1; memRspData_i = beats[i];
         flush_i = (flush_kind == 2 && flush_beat == i);
         if (i == 0) begin
            if (hold_miss) missAddr_i = alt_addr;
            else miss_i = 1'b0;
         end
         cycle_obs();
         if (flush_kind == 1 && flush_beat == i) begin
            @(negedge clk); memRspValid_i = 1'b0; flush_i = 1'b1; cycle_obs();
         end
      end
      @(negedge clk);
      memRspValid_i = 1'b0; memRspData_i = {$urandom, $urandom}; flush_i = (flush_kind == 3);
      cycle_obs();
      busy_after_last = busy_o;
      n = 0;
      while (busy_o && n < 10) begin
         @(negedge clk); flush_i = 1'b0; cycle_obs(); n++;
      end
      if (busy_o) timeout++;
      flush_i = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; miss_i = 1'b0; missAddr_i = 32'd0; flush_i = 1'b0;
      memReqReady_i = 1'b0; memRspValid_i = 1'b0; memRspData_i = 64'd0;
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
      vectors++; if (memReqValid_o !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %0b expected 0", memReqValid_o); end
      vectors++; if (wrEnable_o !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %0b expected 0", wrEnable_o); end
      vectors++; if (memReqAddr_o !== 32'd0) begin miscompares++; $display("FAIL reset_req_addr: got %h expected 0", memReqAddr_o); end
      vectors++; if (wrAddr_o !== 32'd0) begin miscompares++; $display("FAIL reset_wr_addr: got %h expected 0", wrAddr_o); end
      vectors++; if (instBlock_o !== 256'd0) begin miscompares++; $display("FAIL reset_block: got %h expected 0", instBlock_o); end
      @(negedge clk); reset = 1'b0;
      @(negedge clk); #1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %0b expected 0", busy_o); end
   endtask

   task automatic test_basic();
      @(negedge clk); miss_i = 1'b1; missAddr_i = 32'h0000_1234; memReqReady_i = 1'b1; #1;
      @(negedge clk); #1;
      vectors++; if (memReqValid_o !== 1'b1) begin miscompares++; $display("FAIL basic_req_valid: got %0b expected 1", memReqValid_o); end
      vectors++; if (memReqAddr_o !== 32'h0000_1220) begin miscompares++; $display("FAIL basic_req_addr: got %h expected 00001220", memReqAddr_o); end
      for (int i = 0; i < BEATS; i++) begin
         @(negedge clk); miss_i = 1'b0; memReqReady_i = 1'b0;
         memRspValid_i = 1'b1; memRspData_i = 64'hA0 + 64'(i); #1;
         vectors++; if (wrEnable_o !== 1'b0) begin miscompares++; $display("FAIL basic_early_wr: got %0b expected 0 at beat %0d", wrEnable_o, i); end
      end
      @(negedge clk); memRspValid_i = 1'b0; #1;
      vectors++; if (wrEnable_o !== 1'b1) begin miscompares++; $display("FAIL basic_wr_en: got %0b expected 1", wrEnable_o); end
      vectors++; if (wrAddr_o !== 32'h0000_1220) begin miscompares++; $display("FAIL basic_wr_addr: got %h expected 00001220", wrAddr_o); end
      vectors++; if (instBlock_o !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin miscompares++; $display("FAIL basic_block: got %h expected a3/a2/a1/a0", instBlock_o); end
      @(negedge clk); #1;
      vectors++; if (wrEnable_o !== 1'b0 || busy_o !== 1'b1) begin miscompares++; $display("FAIL basic_hold: got wr=%0b busy=%0b expected wr=0 busy=1", wrEnable_o, busy_o); end
      @(negedge clk); #1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL basic_idle: got %0b expected 0", busy_o); end
   endtask

   task automatic test_backpressure();
      logic [31:0] addr;
      for (int it = 0; it < 8; it++) begin
         addr = $urandom;
         randomize_beats();
         run_refill(addr, (it == 0) ? 2 : int'($urandom_range(4, 0)), 3, 0, 0, 1'b0, 32'd0);
         vectors++; if (accept_cnt !== 1) begin miscompares++; $display("FAIL bp_accepts: got %0d expected 1", accept_cnt); end
         vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL bp_addr_stable: got %0d changes expected 0", unstable); end
         vectors++; if (accepted_addr !== model_addr(addr)) begin miscompares++; $display("FAIL bp_req_addr: got %h expected %h", accepted_addr, model_addr(addr)); end
         vectors++; if (pulse_cnt !== 1) begin miscompares++; $display("FAIL bp_pulses: got %0d expected 1", pulse_cnt); end
         vectors++; if (last_wr_addr !== model_addr(addr)) begin miscompares++; $display("FAIL bp_wr_addr: got %h expected %h", last_wr_addr, model_addr(addr)); end
         vectors++; if (last_wr_block !== model_block()) begin miscompares++; $display("FAIL bp_block: got %h expected %h", last_wr_block, model_block()); end
         vectors++; if (timeout !== 0) begin miscompares++; $display("FAIL bp_timeout: got %0d expected 0", timeout); end
      end
   endtask

   task automatic test_flush_resp();
      randomize_beats();
      run_refill(32'h0000_3344, 0, 0, 1, 1, 1'b0, 32'd0);
      vectors++; if (pulse_cnt !== 0) begin miscompares++; $display("FAIL fr_pulses: got %0d expected 0", pulse_cnt); end
      vectors++; if (accept_cnt !== 1) begin miscompares++; $display("FAIL fr_accepts: got %0d expected 1", accept_cnt); end
      vectors++; if (busy_after_last !== 1'b0) begin miscompares++; $display("FAIL fr_busy_after_last: got %0b expected 0", busy_after_last); end
      randomize_beats();
      run_refill($urandom, 0, 2, 2, 3, 1'b0, 32'd0);
      vectors++; if (pulse_cnt !== 0 || busy_after_last !== 1'b0) begin miscompares++; $display("FAIL fr_flush_with_last: got pulses=%0d busy=%0b expected 0/0", pulse_cnt, busy_after_last); end
      randomize_beats();
      run_refill(32'h0000_2000, 0, 0, 0, 0, 1'b0, 32'd0);
      vectors++; if (pulse_cnt !== 1) begin miscompares++; $display("FAIL fr_next_pulses: got %0d expected 1", pulse_cnt); end
      vectors++; if (last_wr_addr !== 32'h0000_2000) begin miscompares++; $display("FAIL fr_next_addr: got %h expected 00002000", last_wr_addr); end
      vectors++; if (last_wr_block !== model_block()) begin miscompares++; $display("FAIL fr_next_block: got %h expected %h", last_wr_block, model_block()); end
   endtask

   task automatic test_flush_req_write();
      accept_cnt = 0; pulse_cnt = 0; valid_seen = 1'b0;
      @(negedge clk); miss_i = 1'b1; missAddr_i = 32'h0000_4567; memReqReady_i = 1'b0; flush_i = 1'b0; cycle_obs();
      @(negedge clk); miss_i = 1'b0; flush_i = 1'b1; memReqReady_i = 1'b1; cycle_obs();
      vectors++; if (memReqValid_o !== 1'b0) begin miscompares++; $display("FAIL freq_valid: got %0b expected 0", memReqValid_o); end
      @(negedge clk); flush_i = 1'b0; cycle_obs();
      vectors++; if (busy_o !== 1'b0 || memReqValid_o !== 1'b0) begin miscompares++; $display("FAIL freq_idle: got busy=%0b valid=%0b expected 0/0", busy_o, memReqValid_o); end
      @(negedge clk); memReqReady_i = 1'b0; cycle_obs();
      vectors++; if (accept_cnt !== 0) begin miscompares++; $display("FAIL freq_accepts: got %0d expected 0", accept_cnt); end
      randomize_beats();
      run_refill($urandom, 1, 1, 3, 0, 1'b0, 32'd0);
      vectors++; if (pulse_cnt !== 0) begin miscompares++; $display("FAIL fwr_pulses: got %0d expected 0", pulse_cnt); end
      vectors++; if (busy_after_last !== 1'b1 || timeout !== 0) begin miscompares++; $display("FAIL fwr_seq: got busy=%0b timeout=%0d expected 1/0", busy_after_last, timeout); end
   endtask

   task automatic test_reset_mid();
      randomize_beats();
      @(negedge clk); miss_i = 1'b1; missAddr_i = 32'h0000_7788; memReqReady_i = 1'b1; #1;
      @(negedge clk); #1;
      @(negedge clk); miss_i = 1'b0; memReqReady_i = 1'b0; memRspValid_i = 1'b1; memRspData_i = beats[0]; #1;
      @(negedge clk); memRspData_i = beats[1]; #1;
      @(negedge clk); memRspValid_i = 1'b0; reset = 1'b1; #1;
      @(negedge clk); reset = 1'b0; memRspValid_i = 1'b1; memRspData_i = {$urandom, $urandom}; #1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %0b expected 0", busy_o); end
      vectors++; if (memReqValid_o !== 1'b0 || wrEnable_o !== 1'b0) begin miscompares++; $display("FAIL rm_strobes: got valid=%0b wr=%0b expected 0/0", memReqValid_o, wrEnable_o); end
      vectors++; if (memReqAddr_o !== 32'd0 || wrAddr_o !== 32'd0) begin miscompares++; $display("FAIL rm_addrs: got req=%h wr=%h expected 0/0", memReqAddr_o, wrAddr_o); end
      vectors++; if (instBlock_o !== 256'd0) begin miscompares++; $display("FAIL rm_block: got %h expected 0", instBlock_o); end
      @(negedge clk); memRspData_i = {$urandom, $urandom}; #1;
      @(negedge clk); memRspValid_i = 1'b0; #1;
      vectors++; if (busy_o !== 1'b0 || wrEnable_o !== 1'b0) begin miscompares++; $display("FAIL rm_stray: got busy=%0b wr=%0b expected 0/0", busy_o, wrEnable_o); end
      randomize_beats();
      run_refill(32'h0000_7788, 0, 1, 0, 0, 1'b0, 32'd0);
      vectors++; if (pulse_cnt !== 1) begin miscompares++; $display("FAIL rm_fresh_pulses: got %0d expected 1", pulse_cnt); end
      vectors++; if (last_wr_block !== model_block()) begin miscompares++; $display("FAIL rm_fresh_block: got %h expected %h", last_wr_block, model_block()); end
      vectors++; if (last_wr_addr !== 32'h0000_7780) begin miscompares++; $display("FAIL rm_fresh_addr: got %h expected 00007780", last_wr_addr); end
   endtask

   task automatic test_miss_held();
      randomize_beats();
      run_refill(32'h0000_5A5C, 1, 2, 0, 0, 1'b1, 32'h0000_9ABC);
      vectors++; if (accept_cnt !== 1 || unstable !== 0) begin miscompares++; $display("FAIL mh_one_req: got accepts=%0d changes=%0d expected 1/0", accept_cnt, unstable); end
      vectors++; if (pulse_cnt !== 1) begin miscompares++; $display("FAIL mh_pulses: got %0d expected 1", pulse_cnt); end
      vectors++; if (last_wr_addr !== 32'h0000_5A40) begin miscompares++; $display("FAIL mh_wr_addr: got %h expected 00005a40", last_wr_addr); end
      vectors++; if (last_wr_block !== model_block()) begin miscompares++; $display("FAIL mh_block: got %h expected %h", last_wr_block, model_block()); end
      vectors++; if (timeout !== 0) begin miscompares++; $display("FAIL mh_hold_ignored: got timeout=%0d expected 0", timeout); end
      @(negedge clk); #1;
      vectors++; if (memReqValid_o !== 1'b1 || memReqAddr_o !== 32'h0000_9AA0) begin miscompares++; $display("FAIL mh_new_req: got valid=%0b addr=%h expected 1/00009aa0", memReqValid_o, memReqAddr_o); end
      @(negedge clk); miss_i = 1'b0; flush_i = 1'b1; #1;
      @(negedge clk); flush_i = 1'b0; #1;
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL mh_abandon: got %0b expected 0", busy_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_flush_resp();
      test_flush_req_write();
      test_reset_mid();
      test_miss_held();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
